// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | rexta (dmem_responder_pkg) - shared types and funct3 codes for dmem_responder|
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
package rexta;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dmem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Size code 2'b11 has no defined width, so it behaves as a word.
  function automatic mem_size_t f3_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b11) ? MEM_W : mem_size_t'(f3[1:0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_lane_align.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dmem_lane_align - byte-lane enables, store replication and load extension   |
// | Macro REXTA_DMEM_MISALIGN_ERR_EN: flag misaligned H/W instead of aligning.  |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module dmem_lane_align
  import rexta::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  mem_size_t   size;
  logic [1:0]  off;
  logic [31:0] shifted;

  always_comb begin
    size     = f3_size(funct3);
    misalign = 1'b0;
    off      = addr_lo;
`ifdef REXTA_DMEM_MISALIGN_ERR_EN
    if (size == MEM_H)      misalign = addr_lo[0];
    else if (size == MEM_W) misalign = |addr_lo;
`else
    if (size == MEM_H)      off = {addr_lo[1], 1'b0};
    else if (size == MEM_W) off = 2'b00;
`endif
    shifted   = rword >> {off, 3'b000};
    be        = 4'hF;
    wdata_sh  = wdata;
    rdata_ext = rword;
    case (size)
      MEM_B: begin
        be        = 4'b0001 << off;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = {{24{~funct3[2] & shifted[7]}}, shifted[7:0]};
      end
      MEM_H: begin
        be        = 4'b0011 << off;
        wdata_sh  = {2{wdata[15:0]}};
        rdata_ext = {{16{~funct3[2] & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be        = 4'hF;
        wdata_sh  = wdata;
        rdata_ext = rword;
      end
    endcase
    // A flagged access must neither write nor return data.
    if (misalign) begin
      be        = 4'h0;
      rdata_ext = 32'h0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dmem_responder - single-outstanding load/store responder, fixed latency     |
// | Macro REXTA_DMEM_MISALIGN_ERR_EN: report misaligned H/W on rsp_err.         |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module dmem_responder
  import rexta::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [1:0] LAST_WAIT = 2'((LATENCY > 1) ? (LATENCY - 2) : 0);

  logic [31:0]       mem [DEPTH_WORDS];
  dmem_state_t       state, state_next;
  logic [1:0]        lat_cnt, lat_cnt_next;
  logic              accept;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        be;
  logic [31:0]       wdata_sh;
  logic [31:0]       rdata_ext;
  logic              misalign;
  logic              unused_addr;

  assign accept      = req_valid & req_ready;
  assign idx         = req_addr[IDX_W+1:2];
  assign req_ready   = (state == DM_IDLE);
  assign rsp_valid   = (state == DM_RESP);
  assign unused_addr = ^req_addr[31:IDX_W+2];

  dmem_lane_align u_lane_align (
    .funct3   (req_funct3),
    .addr_lo  (req_addr[1:0]),
    .wdata    (req_wdata),
    .rword    (mem[idx]),
    .be       (be),
    .wdata_sh (wdata_sh),
    .rdata_ext(rdata_ext),
    .misalign (misalign)
  );

  always_comb begin
    state_next   = state;
    lat_cnt_next = lat_cnt;
    case (state)
      DM_IDLE: begin
        if (accept) begin
          lat_cnt_next = 2'd0;
          state_next   = (LATENCY > 1) ? DM_WAIT : DM_RESP;
        end
      end
      DM_WAIT: begin
        if (lat_cnt == LAST_WAIT) state_next   = DM_RESP;
        else                      lat_cnt_next = lat_cnt + 2'd1;
      end
      DM_RESP: begin
        if (rsp_ready) state_next = DM_IDLE;
      end
      default: state_next = DM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DM_IDLE;
      lat_cnt   <= 2'd0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state   <= state_next;
      lat_cnt <= lat_cnt_next;
      // Response registers load only on accept, so they hold under back-pressure.
      if (accept) begin
        rsp_rdata <= req_we ? 32'h0 : rdata_ext;
        rsp_err   <= misalign;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept && req_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// Scoreboard bench: instance 0 uses LATENCY=1, instance 1 uses LATENCY=3.
module tb_dmem_responder;
  import rexta::*;

`ifdef REXTA_DMEM_MISALIGN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    int          t_acc;
  } exp_t;

  logic        clk;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_funct3[2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t q0[$];
  exp_t q1[$];

  int          t_valid   [2];
  logic        prev_valid[2];
  logic        prev_stall[2];
  logic [31:0] held_rdata[2];
  logic        held_err  [2];

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut1 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        prev_valid[d] = 1'b0;
        prev_stall[d] = 1'b0;
      end else begin
        if (rsp_valid[d]) begin
          exp_t e;
          if (!prev_valid[d]) t_valid[d] = cyc;
          check("no_overlap_req_ready", {31'b0, req_ready[d]}, 32'h0);
          if (prev_stall[d]) begin
            check("stall_rdata_stable", rsp_rdata[d], held_rdata[d]);
            check("stall_err_stable", {31'b0, rsp_err[d]}, {31'b0, held_err[d]});
          end
          if (rsp_ready[d]) begin
            prev_stall[d] = 1'b0;
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
              check("unexpected_response", 32'h1, 32'h0);
            end else begin
              e = (d == 0) ? q0.pop_front() : q1.pop_front();
              check("rsp_rdata", rsp_rdata[d], e.rdata);
              check("rsp_err", {31'b0, rsp_err[d]}, {31'b0, e.err});
              check("rsp_latency", t_valid[d] - e.t_acc, (d == 0) ? 32'd1 : 32'd3);
            end
          end else begin
            prev_stall[d] = 1'b1;
            held_rdata[d] = rsp_rdata[d];
            held_err[d]   = rsp_err[d];
          end
        end else begin
          prev_stall[d] = 1'b0;
        end
        prev_valid[d] = rsp_valid[d];
      end
    end
  end

  task automatic issue(input int d, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
    int   guard = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready[d]) begin
      check("req_ready_timeout", 32'h0, 32'h1);
      return;
    end
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_addr[d]   = a;
    req_wdata[d]  = wd;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.t_acc = cyc;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(negedge clk);
    req_valid[d]  = 1'b0;
    req_addr[d]   = 32'hFFFF_FFFF;
    req_wdata[d]  = 32'h5555_5555;
  endtask

  task automatic drain();
    int guard = 0;
    while ((q0.size() != 0 || q1.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_scoreboard_empty", q0.size() + q1.size(), 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = 3'b0;
      req_addr[d] = 32'h0; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("reset_req_ready", {31'b0, req_ready[d]}, 32'h1);
      check("reset_rsp_valid", {31'b0, rsp_valid[d]}, 32'h0);
      check("reset_rsp_rdata", rsp_rdata[d], 32'h0);
      check("reset_rsp_err", {31'b0, rsp_err[d]}, 32'h0);
    end

    // Word store/load
    issue(0, 1, F3_SW,  32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    issue(0, 0, F3_LW,  32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    // Byte lanes and extension
    issue(0, 1, F3_SB,  32'h13, 32'h000000A5, 32'h0, 1'b0);
    issue(0, 0, F3_LB,  32'h13, 32'h0, 32'hFFFFFFA5, 1'b0);
    issue(0, 0, F3_LBU, 32'h13, 32'h0, 32'h000000A5, 1'b0);
    issue(0, 0, F3_LW,  32'h10, 32'h0, 32'hA5ADBEEF, 1'b0);
    issue(0, 0, F3_LB,  32'h11, 32'h0, 32'hFFFFFFBE, 1'b0);
    issue(0, 0, F3_LHU, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
    issue(0, 0, F3_LH,  32'h12, 32'h0, 32'hFFFFA5AD, 1'b0);
    issue(0, 0, 3'b011, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0);
    // Address wrap modulo 4 KiB
    issue(0, 0, F3_LW,  32'h1010, 32'h0, 32'hA5ADBEEF, 1'b0);
    // Halfword lanes
    issue(0, 1, F3_SW,  32'h20, 32'h0, 32'h0, 1'b0);
    issue(0, 1, F3_SH,  32'h22, 32'hFFFF8001, 32'h0, 1'b0);
    issue(0, 0, F3_LH,  32'h22, 32'h0, 32'hFFFF8001, 1'b0);
    issue(0, 0, F3_LHU, 32'h22, 32'h0, 32'h00008001, 1'b0);
    issue(0, 0, F3_LH,  32'h20, 32'h0, 32'h00000000, 1'b0);
    // Misaligned accesses
    issue(0, 0, F3_LW,  32'h11, 32'h0, ERR_EN ? 32'h0 : 32'hA5ADBEEF, ERR_EN);
    issue(0, 0, F3_LH,  32'h13, 32'h0, ERR_EN ? 32'h0 : 32'hFFFFA5AD, ERR_EN);
    issue(0, 0, F3_LHU, 32'h11, 32'h0, ERR_EN ? 32'h0 : 32'h0000BEEF, ERR_EN);
    issue(0, 1, F3_SW,  32'h14, 32'h0, 32'h0, 1'b0);
    issue(0, 1, F3_SW,  32'h16, 32'h12345678, 32'h0, ERR_EN);
    issue(0, 0, F3_LW,  32'h14, 32'h0, ERR_EN ? 32'h0 : 32'h12345678, 1'b0);

    // LATENCY=3 with back-pressure
    issue(1, 1, F3_SW, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0);
    drain();
    rsp_ready[1] = 1'b0;
    issue(1, 0, F3_LW, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0);
    begin
      int guard = 0;
      while (!rsp_valid[1] && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      check("lat3_valid_seen", {31'b0, rsp_valid[1]}, 32'h1);
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rsp_ready[1] = 1'b1;
    drain();

    // Reset during WAIT drops the response but keeps memory
    issue(1, 0, F3_LW, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0);
    rst[1] = 1'b1;
    check("drop_queue_depth", q1.size(), 32'd1);
    if (q1.size() != 0) void'(q1.pop_back());
    @(negedge clk);
    rst[1] = 1'b0;
    check("post_rst_rsp_valid", {31'b0, rsp_valid[1]}, 32'h0);
    check("post_rst_req_ready", {31'b0, req_ready[1]}, 32'h1);
    issue(1, 0, F3_LW, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0);
    drain();

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
